riscv_mem_arbiter: RTL and testbench

//   Shares one single-port word RAM between the instruction-fetch and load/store units of the core.
//   - Each requester uses a valid/ready request channel and a one-cycle response pulse.
//   - The block arbitrates between them, latches the winning request and drives the RAM for one cycle.
//   - It then returns read data to the owner.
//   - It sits between the core pipeline and the memory; the RAM itself lives outside this block.

---
 rtl/riscv_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares one single-port word RAM between ifetch and load/store.
//               Optional fairness starve counter: RISCV_ARB_FAIRNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int WORD_LENGTH  = 32,
    parameter int NUM_MEM      = 4096,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_req_valid,
    output logic                          if_req_ready,
    input  logic [WORD_LENGTH-1:0]        if_addr,
    output logic                          if_resp_valid,
    output logic [WORD_LENGTH-1:0]        if_rdata,
    input  logic                          d_req_valid,
    output logic                          d_req_ready,
    input  logic [WORD_LENGTH-1:0]        d_addr,
    input  logic                          d_we,
    input  logic [WORD_LENGTH-1:0]        d_wdata,
    output logic                          d_resp_valid,
    output logic [WORD_LENGTH-1:0]        d_rdata,
    output logic [$clog2(NUM_MEM)-1:0]    mem_addr,
    output logic                          mem_we,
    output logic [WORD_LENGTH-1:0]        mem_wdata,
    input  logic [WORD_LENGTH-1:0]        mem_rdata
);

    localparam int c_ADDR_BITS = $clog2(NUM_MEM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [WORD_LENGTH-1:0]  r_addr;
    logic [WORD_LENGTH-1:0]  r_wdata;
    logic                    r_we;
    logic                    r_owner_d;
    logic                    r_mem_we;
    logic                    r_if_resp;
    logic                    r_d_resp;
    logic [WORD_LENGTH-1:0]  r_if_rdata;
    logic [WORD_LENGTH-1:0]  r_d_rdata;

    logic                    w_idle;
    logic                    w_d_grant;
    logic                    w_if_grant;

    assign w_idle = (r_state == S_IDLE);

`ifdef RISCV_ARB_FAIRNESS_EN
    localparam int c_CNT_BITS = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_BITS-1:0] c_LIMIT = c_CNT_BITS'(STARVE_LIMIT);

    logic [c_CNT_BITS-1:0]   r_starve;
    logic                    w_if_turn;

    assign w_if_turn  = (r_starve == c_LIMIT);
    assign w_d_grant  = w_idle && d_req_valid && !(if_req_valid && w_if_turn);
    assign w_if_grant = w_idle && if_req_valid && (!d_req_valid || w_if_turn);

    // Counts data grants that overtook a waiting fetch; any gap in fetch demand forgives them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!if_req_valid || w_if_grant) begin
            r_starve <= '0;
        end else if (w_d_grant) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    logic                    w_unused_cfg;

    assign w_d_grant    = w_idle && d_req_valid;
    assign w_if_grant   = w_idle && if_req_valid && !d_req_valid;
    assign w_unused_cfg = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_owner_d  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_resp  <= 1'b0;
            r_d_resp   <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_mem_we  <= 1'b0;
            r_if_resp <= 1'b0;
            r_d_resp  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_grant) begin
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                        r_we      <= d_we;
                        r_owner_d <= 1'b1;
                        r_mem_we  <= d_we;
                        r_state   <= S_ACCESS;
                    end else if (w_if_grant) begin
                        r_addr    <= if_addr;
                        r_we      <= 1'b0;
                        r_owner_d <= 1'b0;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        if (r_owner_d) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                    end
                    r_if_resp <= !r_owner_d;
                    r_d_resp  <= r_owner_d;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address bits above the RAM depth are dropped so accesses wrap modulo NUM_MEM.
    logic w_unused_addr;
    assign w_unused_addr = ^r_addr[WORD_LENGTH-1:c_ADDR_BITS];

    assign if_req_ready  = w_if_grant;
    assign d_req_ready   = w_d_grant;
    assign mem_addr      = r_addr[c_ADDR_BITS-1:0];
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_wdata;
    assign if_resp_valid = r_if_resp;
    assign d_resp_valid  = r_d_resp;
    assign if_rdata      = r_if_rdata;
    assign d_rdata       = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mem_arbiter
// Description : Self-checking bench for riscv_mem_arbiter with a RAM model and
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

    localparam int WL = 32;
    localparam int NM = 4096;
    localparam int AB = 12;
    localparam int SL = 4;
`ifdef RISCV_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [WL-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [WL-1:0] if_rdata;
    logic          d_req_valid = 1'b0;
    logic          d_req_ready;
    logic [WL-1:0] d_addr = '0;
    logic          d_we = 1'b0;
    logic [WL-1:0] d_wdata = '0;
    logic          d_resp_valid;
    logic [WL-1:0] d_rdata;
    logic [AB-1:0] mem_addr;
    logic          mem_we;
    logic [WL-1:0] mem_wdata;
    logic [WL-1:0] mem_rdata;

    riscv_mem_arbiter #(.WORD_LENGTH(WL), .NUM_MEM(NM), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External RAM: combinational read, write on rising edge.
    logic [WL-1:0] ram [NM];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string nm, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // Reference model: transaction timestamps plus its own copy of memory.
    logic [WL-1:0] model_mem [NM];
    int            cyc = 0;
    int            acc = -10;
    bit            p_d, p_we;
    logic [WL-1:0] p_addr, p_wdata;
    logic [WL-1:0] h_if = '0, h_d = '0;
    int            starve = 0;
    bit            busy, g_d, g_i, in_acc, in_resp;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; acc = -10; h_if = '0; h_d = '0; starve = 0;
        end else begin
            in_acc  = (cyc == acc + 1);
            in_resp = (cyc == acc + 2);
            busy    = in_acc || in_resp;
            g_d = 1'b0; g_i = 1'b0;
            if (!busy) begin
                if (d_req_valid && if_req_valid) begin
                    if (FAIR && starve >= SL) g_i = 1'b1;
                    else                      g_d = 1'b1;
                end else begin
                    g_d = d_req_valid;
                    g_i = if_req_valid;
                end
            end
            chk("if_req_ready", if_req_ready, g_i);
            chk("d_req_ready", d_req_ready, g_d);
            chk("mem_we", mem_we, in_acc && p_we);
            if (in_acc) chk("mem_addr", mem_addr, p_addr % NM);
            if (in_acc && p_we) chk("mem_wdata", mem_wdata, p_wdata);
            chk("if_resp_valid", if_resp_valid, in_resp && !p_d);
            chk("d_resp_valid", d_resp_valid, in_resp && p_d);
            chk("if_rdata", if_rdata, h_if);
            chk("d_rdata", d_rdata, h_d);
            if (in_acc) begin
                if (p_we)     model_mem[int'(p_addr % NM)] = p_wdata;
                else if (p_d) h_d  = model_mem[int'(p_addr % NM)];
                else          h_if = model_mem[int'(p_addr % NM)];
            end
            if (g_d || g_i) begin
                acc = cyc; p_d = g_d; p_addr = g_d ? d_addr : if_addr;
                p_we = g_d && d_we; p_wdata = d_wdata;
            end
            if (!if_req_valid || g_i) starve = 0;
            else if (g_d)             starve++;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_mem(input int a, input logic [WL-1:0] v);
        ram[a] <= v;
        model_mem[a] = v;
    endtask

    // Hold a data request until accepted; returns at the start of the ACCESS cycle.
    task automatic d_req(input logic [WL-1:0] a, input logic we, input logic [WL-1:0] wd, output int lat);
        d_req_valid = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (d_req_ready) begin lat = k; tick(); break; end
            tick();
        end
        d_req_valid = 1'b0;
        chk("d_accept_in_budget", lat >= 0, 1);
    endtask

    task automatic if_req(input logic [WL-1:0] a, output int lat);
        if_req_valid = 1'b1; if_addr = a;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (if_req_ready) begin lat = k; tick(); break; end
            tick();
        end
        if_req_valid = 1'b0;
        chk("if_accept_in_budget", lat >= 0, 1);
    endtask

    function automatic logic [WL-1:0] rand_addr();
        logic [WL-1:0] a;
        a = WL'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) a = a + WL'(NM * $urandom_range(1, 5));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [WL-1:0] v;
        int            lat, ng, pulses, exp_pulses;
        byte           got [10];
        byte           expg [10];
        bit            acc_i, acc_d;

        for (int i = 0; i < NM; i++) begin
            v = $urandom;
            set_mem(i, v);
        end
        repeat (3) @(negedge clk);
        chk("rst_if_req_ready", if_req_ready, 0);
        chk("rst_d_req_ready", d_req_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valids", {if_resp_valid, d_resp_valid}, 0);
        chk("rst_rdatas", if_rdata | d_rdata, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Single load: ready at T, ACCESS at T+1, response at T+2 only.
        set_mem(5, 32'hDEADBEEF); tick();
        d_req(5, 1'b0, '0, lat);
        chk("load_ready_at_T", lat, 0);
        chk("load_mem_addr", mem_addr, 5);
        chk("load_mem_we", mem_we, 0);
        chk("load_no_early_resp", d_resp_valid, 0);
        tick();
        chk("load_resp_valid", d_resp_valid, 1);
        chk("load_rdata", d_rdata, 32'hDEADBEEF);
        tick();
        chk("load_resp_one_cycle", d_resp_valid, 0);
        chk("load_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Store then fetch of the same word.
        d_req(8, 1'b1, 32'h00000013, lat);
        chk("store_mem_we", mem_we, 1);
        chk("store_mem_addr", mem_addr, 8);
        chk("store_mem_wdata", mem_wdata, 32'h00000013);
        tick();
        chk("store_we_one_cycle", mem_we, 0);
        chk("store_ack", d_resp_valid, 1);
        chk("store_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
        tick();
        if_req(8, lat);
        tick();
        chk("fetch_resp_valid", if_resp_valid, 1);
        chk("fetch_rdata", if_rdata, 32'h00000013);
        tick();

        // Out-of-range address wraps modulo NUM_MEM.
        set_mem(3, 32'hCAFE0003); tick();
        d_req(NM + 3, 1'b0, '0, lat);
        chk("wrap_mem_addr", mem_addr, 3);
        tick();
        chk("wrap_rdata", d_rdata, 32'hCAFE0003);
        tick(); tick();

        // Continuous contention from both requesters.
        for (int i = 0; i < 10; i++) begin
            got[i]  = "-";
            expg[i] = (FAIR && (i % 5 == 4)) ? "I" : "D";
        end
        exp_pulses = 0;
        for (int i = 0; i < 10; i++) if (expg[i] == "I") exp_pulses++;
        d_req_valid = 1'b1; d_addr = 40; d_we = 1'b0;
        if_req_valid = 1'b1; if_addr = 41;
        ng = 0; pulses = 0;
        for (int k = 0; k < 200 && ng < 10; k++) begin
            #3;
            if (if_resp_valid) pulses++;
            if (d_req_ready) begin got[ng] = "D"; ng++; end
            else if (if_req_ready) begin got[ng] = "I"; ng++; end
            tick();
        end
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            if (if_resp_valid) pulses++;
            tick();
        end
        chk("contention_grant_count", ng, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("contention_grant_%0d", i), got[i], expg[i]);
        chk("contention_if_pulses", pulses, exp_pulses);
        tick();

        // Reset during a store's ACCESS cycle: write must never land.
        set_mem(20, 32'h11111111); tick();
        d_req(20, 1'b1, 32'hBAD0BAD0, lat);
        chk("rstmid_mem_we_before", mem_we, 1);
        #1; rst = 1'b1; #1;
        chk("rstmid_mem_we", mem_we, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_mem_wdata", mem_wdata, 0);
        chk("rstmid_readys", {if_req_ready, d_req_ready}, 0);
        chk("rstmid_rdatas", if_rdata | d_rdata, 0);
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstmid_no_resp", {if_resp_valid, d_resp_valid}, 0);
            tick();
        end
        chk("rstmid_ram_unchanged", ram[20], 32'h11111111);

        // Randomized traffic obeying the hold-until-ready rule.
        acc_i = 1'b1; acc_d = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!if_req_valid || acc_i) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_addr      = rand_addr();
            end
            if (!d_req_valid || acc_d) begin
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_addr      = rand_addr();
                d_we        = $urandom_range(0, 1) == 1;
                d_wdata     = $urandom;
            end
            #3;
            acc_i = if_req_valid && if_req_ready;
            acc_d = d_req_valid && d_req_ready;
            tick();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
